vga_frame_updater: RTL and testbench

Upstream feeder for the VGA central controller's 16-entry pointer memory. Holds a 16×8 shadow register file written by a host at any time, marks changed entries dirty, and on each vertical-sync assertion streams only dirty entries to the VGA controller as address/data write pairs on ports 40/41. Confining updates to the vertical interval gives tear-free frames without host involvement.

---
 rtl/vga_frame_updater.sv | 124 ++++++++++++
 tb/tb_vga_frame_updater.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_updater.sv
// Shadow copy of the VGA controller's 16-entry pointer memory. Host writes mark
// entries dirty; each VSync falling edge streams the dirty entries out as port 40/41 write pairs.
module vga_frame_updater (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh_all,
    input  logic       VSync,
    output logic [7:0] Port_ID,
    output logic [7:0] OUT_PORT,
    output logic       Write_Strobe,
    output logic       busy,
    output logic       overrun
);
    localparam logic [7:0] ADDR_PORT = 8'd40;
    localparam logic [7:0] DATA_PORT = 8'd41;

    typedef enum logic [1:0] {IDLE, SCAN, ADDR, DATA} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic        vs_q_reg;
    logic [7:0]  shadow_reg [16];
    logic [15:0] dirty_reg, dirty_next;
    logic [7:0]  port_id_reg, port_id_next;
    logic [7:0]  out_port_reg, out_port_next;
    logic        strobe_reg, strobe_next;
    logic        busy_reg, overrun_reg;
    logic        vs_fall;

    assign vs_fall = vs_q_reg & ~VSync;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        port_id_next  = 8'h00;
        out_port_next = 8'h00;
        strobe_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vs_fall) begin
                    idx_next   = 4'd0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (dirty_reg[idx_reg]) begin
                    state_next = ADDR;
                end else if (idx_reg == 4'd15) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end
            ADDR: begin
                port_id_next  = ADDR_PORT;
                out_port_next = {4'h0, idx_reg};
                strobe_next   = 1'b1;
                state_next    = DATA;
            end
            DATA: begin
                // Shadow value as it stood before this edge; a concurrent host
                // write to the same entry leaves it dirty for the next frame.
                port_id_next  = DATA_PORT;
                out_port_next = shadow_reg[idx_reg];
                strobe_next   = 1'b1;
                if (idx_reg == 4'd15) begin
                    state_next = IDLE;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = SCAN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Set sources (host write, refresh) take priority over the flush clear.
    for (genvar gi = 0; gi < 16; gi++) begin : g_dirty
        assign dirty_next[gi] = refresh_all
                              | (wr_en && (wr_addr == 4'(gi)))
                              | (dirty_reg[gi] & ~((state_reg == DATA) && (idx_reg == 4'(gi))));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) shadow_reg[i] <= 8'h00;
        end else if (wr_en) begin
            shadow_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            idx_reg      <= 4'd0;
            vs_q_reg     <= 1'b1;
            dirty_reg    <= 16'h0000;
            port_id_reg  <= 8'h00;
            out_port_reg <= 8'h00;
            strobe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            vs_q_reg     <= VSync;
            dirty_reg    <= dirty_next;
            port_id_reg  <= port_id_next;
            out_port_reg <= out_port_next;
            strobe_reg   <= strobe_next;
            busy_reg     <= (state_next != IDLE);
            overrun_reg  <= vs_fall && (state_reg != IDLE);
        end
    end

    assign Port_ID      = port_id_reg;
    assign OUT_PORT     = out_port_reg;
    assign Write_Strobe = strobe_reg;
    assign busy         = busy_reg;
    assign overrun      = overrun_reg;
endmodule

// File: tb/tb_vga_frame_updater.sv
// Directed bench for vga_frame_updater: captures every strobe pair and busy/overrun
// cycles, and compares each frame against a shadow model kept by the bench.
module tb_vga_frame_updater;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh_all;
    logic       VSync;
    logic [7:0] Port_ID;
    logic [7:0] OUT_PORT;
    logic       Write_Strobe;
    logic       busy;
    logic       overrun;

    vga_frame_updater dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh_all(refresh_all), .VSync(VSync), .Port_ID(Port_ID), .OUT_PORT(OUT_PORT),
        .Write_Strobe(Write_Strobe), .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] strobes [$];
    int busy_cnt = 0, ov_cnt = 0, idle_err = 0, pair_err = 0;
    logic prev_addr = 1'b0;
    logic [7:0] shadow_m [16];
    int exp_idx [$];

    always @(negedge CLK) begin
        if (Write_Strobe) strobes.push_back({Port_ID, OUT_PORT});
        else if (Port_ID != 8'h00 || OUT_PORT != 8'h00) idle_err <= idle_err + 1;
        if (prev_addr && !(Write_Strobe && Port_ID == 8'd41)) pair_err <= pair_err + 1;
        prev_addr <= Write_Strobe && (Port_ID == 8'd40);
        if (busy) busy_cnt <= busy_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow_m[a] = d;
    endtask

    task automatic pulse_refresh();
        refresh_all = 1'b1;
        tick();
        refresh_all = 1'b0;
    endtask

    // One frame: VSync falls, optional second edge at loop step ov_at, optional
    // host write timed onto the DATA cycle of entry inj_idx.
    task automatic run_frame(input int ov_at, input int inj_idx, input logic [7:0] inj_data);
        int k;
        strobes.delete();
        busy_cnt = 0; ov_cnt = 0;
        VSync = 1'b0; tick(); tick(); VSync = 1'b1;
        k = 0;
        while (busy && k < 100) begin
            VSync = (ov_at >= 0 && (k == ov_at || k == ov_at + 1)) ? 1'b0 : 1'b1;
            if (inj_idx >= 0 && Write_Strobe && Port_ID == 8'd40 && OUT_PORT == 8'(inj_idx)) begin
                wr_en = 1'b1; wr_addr = 4'(inj_idx); wr_data = inj_data;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            k++;
        end
        VSync = 1'b1; wr_en = 1'b0;
        chk("flush_timeout", 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    task automatic check_flush(input string tag, input int exp_busy);
        chk({tag, "_busy"}, busy_cnt, exp_busy);
        chk({tag, "_count"}, strobes.size(), 2 * exp_idx.size());
        foreach (exp_idx[i]) begin
            if (2 * i + 1 < strobes.size()) begin
                chk({tag, "_addr"}, 32'(strobes[2*i]), {16'h0, 8'd40, 4'h0, 4'(exp_idx[i])});
                chk({tag, "_data"}, 32'(strobes[2*i+1]), {16'h0, 8'd41, shadow_m[exp_idx[i]]});
            end
        end
    endtask

    task automatic all_idx();
        exp_idx.delete();
        for (int i = 0; i < 16; i++) exp_idx.push_back(i);
    endtask

    initial begin
        RESET = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
        refresh_all = 1'b0; VSync = 1'b1;
        for (int i = 0; i < 16; i++) shadow_m[i] = 8'h00;
        repeat (3) tick();
        RESET = 1'b0;
        chk("reset_port_id", 32'(Port_ID), 32'd0);
        chk("reset_out_port", 32'(OUT_PORT), 32'd0);
        chk("reset_strobe", 32'(Write_Strobe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // Empty frame: 16 SCAN cycles, nothing sent.
        exp_idx.delete();
        run_frame(-1, -1, 8'h00);
        check_flush("empty", 16);

        // Two sparse entries.
        do_write(3, 8'hA5);
        do_write(12, 8'h3C);
        exp_idx = '{3, 12};
        run_frame(-1, -1, 8'h00);
        check_flush("sparse", 20);
        exp_idx.delete();
        run_frame(-1, -1, 8'h00);
        check_flush("sparse_clean", 16);

        // All entries written; second VSync edge mid-flush must only pulse overrun.
        for (int i = 0; i < 16; i++) do_write(i, 8'(i * 37 + 5));
        all_idx();
        run_frame(10, -1, 8'h00);
        check_flush("full_ovr", 48);
        chk("overrun_pulses", ov_cnt, 1);
        exp_idx.delete();
        run_frame(-1, -1, 8'h00);
        check_flush("full_clean", 16);
        chk("no_overrun", ov_cnt, 0);

        // refresh_all resends everything.
        pulse_refresh();
        all_idx();
        run_frame(-1, -1, 8'h00);
        check_flush("refresh", 48);

        // Host write collides with DATA cycle of entry 5.
        do_write(5, 8'h11);
        exp_idx = '{5};
        run_frame(-1, 5, 8'h77);
        check_flush("collide", 18);
        shadow_m[5] = 8'h77;
        run_frame(-1, -1, 8'h00);
        check_flush("collide_next", 18);

        // Reset landing on the ADDR cycle of entry 2.
        do_write(2, 8'h22);
        do_write(9, 8'h99);
        strobes.delete();
        VSync = 1'b0; tick();
        VSync = 1'b1; tick(); tick(); tick();
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("rst_mid_strobe", 32'(Write_Strobe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("rst_mid_no_strobes", strobes.size(), 0);
        for (int i = 0; i < 16; i++) shadow_m[i] = 8'h00;
        exp_idx.delete();
        run_frame(-1, -1, 8'h00);
        check_flush("post_rst", 16);
        pulse_refresh();
        all_idx();
        run_frame(-1, -1, 8'h00);
        check_flush("post_rst_refresh", 48);

        chk("idle_outputs_zero", idle_err, 0);
        chk("addr_data_adjacent", pair_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
